noc_credit_link_pipe: RTL and testbench
=======================================

Name: noc_credit_link_pipe

Overview:
- Multi-channel, credit-based, pipelined router-to-router link stage for the mesh NoC.
- Inserts NUM_PIPELINE register stages on the forward path (data/dest/is_tail/send) and the same number on the reverse path (credit) for each of NUM_LINKS independent links.
- Contains a per-link credit monitor that tracks downstream buffer occupancy as seen by the upstream router, and flags credit protocol violations.
- Instantiated between adjacent router wrappers, one instance per router side.

Parameters:
- NUM_LINKS, 4, number of independent links (router ports minus local).
- FLIT_WIDTH, 128, flit payload width.
- DEST_WIDTH, 6, destination field width (TDEST_WIDTH + TID_WIDTH).
- NUM_PIPELINE, 1, register stages per direction; 0 to 8 legal; 0 = combinational pass-through.
- FLIT_BUFFER_DEPTH, 4, downstream input buffer depth; this is the credit counter reset value.
- CNT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width (derived).

Ports:
- clk_noc  in  1  NoC clock.
- rst_noc_sync  in  1  synchronous active-high reset.
- data_in  in  [0:NUM_LINKS-1][FLIT_WIDTH-1:0]  flits from upstream router.
- dest_in  in  [0:NUM_LINKS-1][DEST_WIDTH-1:0]  destinations from upstream.
- is_tail_in  in  [0:NUM_LINKS-1]  tail marker from upstream.
- send_in  in  [0:NUM_LINKS-1]  flit valid from upstream.
- credit_out  out  [0:NUM_LINKS-1]  delayed credit returned to upstream.
- data_out  out  [0:NUM_LINKS-1][FLIT_WIDTH-1:0]  flits to downstream.
- dest_out  out  [0:NUM_LINKS-1][DEST_WIDTH-1:0]  destinations to downstream.
- is_tail_out  out  [0:NUM_LINKS-1]  tail marker to downstream.
- send_out  out  [0:NUM_LINKS-1]  flit valid to downstream.
- credit_in  in  [0:NUM_LINKS-1]  credit from downstream router.
- credits_avail  out  [0:NUM_LINKS-1][CNT_WIDTH-1:0]  credits held by upstream.
- err_overflow  out  [0:NUM_LINKS-1]  sticky: send issued with zero credits.
- err_underflow  out  [0:NUM_LINKS-1]  sticky: credit returned with counter already full.
- in_packet  out  [0:NUM_LINKS-1]  a non-tail flit has passed and its tail has not yet arrived.
- perf_clear  in  1  synchronous clear for the performance counters.
- flit_count  out  [0:NUM_LINKS-1][31:0]  forwarded-flit counter.
- pkt_count  out  [0:NUM_LINKS-1][31:0]  forwarded-packet (tail) counter.

Behaviour:
- One clock domain (clk_noc). Reset is synchronous, active-high (rst_noc_sync), sampled on the rising edge.
- Reset values:
  - send_out, is_tail_out, credit_out, data_out, dest_out: 0.
  - All internal pipeline stages: 0.
  - credits_avail: FLIT_BUFFER_DEPTH.
  - err_*, in_packet: 0.
  - Counters: 0.
- Forward path: send_out[k] equals send_in[k] delayed exactly NUM_PIPELINE cycles; data/dest/is_tail are delayed identically.
  - Data stage enables are qualified by send; the valid bit is never gated.
- Reverse path: credit_out[k] equals credit_in[k] delayed exactly NUM_PIPELINE cycles.
- NUM_PIPELINE=0: all outputs are combinational copies of their inputs. The credit monitor stays registered.
- Links are fully independent; there is no cross-link arbitration.
- Credit monitor, per link, sampled at the upstream side (send_in, credit_out):
  - send_in only: decrement.
  - credit_out only: increment.
  - Both in the same cycle: hold.
  - send_in with count 0 and no simultaneous credit_out: set err_overflow, hold at 0 (no wrap).
  - credit_out with count FLIT_BUFFER_DEPTH and no simultaneous send_in: set err_underflow, hold at max (no wrap).
  - Errors clear only on reset.
- in_packet, per link, sampled at send_out:
  - Set on send_out & ~is_tail_out.
  - Cleared on send_out & is_tail_out.
  - A single-flit packet leaves it at 0.
- Reset mid-packet: in-flight pipeline contents are discarded, and the counter returns to FLIT_BUFFER_DEPTH on the next edge.
- Round-trip credit latency grows by 2*NUM_PIPELINE cycles. Sustaining full throughput requires FLIT_BUFFER_DEPTH >= router round-trip + 2*NUM_PIPELINE. This block does not enforce that.

Optional Feature:
- Macro: NOC_LINK_PERF_CNT_EN.
- Defined:
  - flit_count[k] increments on each send_out[k].
  - pkt_count[k] increments on each send_out[k] & is_tail_out[k].
  - Both are 32-bit and saturate at 32'hFFFFFFFF.
  - perf_clear zeroes all counters on the next edge and takes priority over an increment in the same cycle.
- Undefined:
  - The counters are not synthesised.
  - flit_count and pkt_count are tied to 0; perf_clear is ignored.
  - Ports stay present.

Test Plan:
- NUM_PIPELINE=2, NUM_LINKS=4: send_in[1]=1 with data 0xA5 at cycle 10 -> send_out[1]=1 and data_out[1]=0xA5 at cycle 12; other links stay 0. credit_in[1] at cycle 20 -> credit_out[1] at cycle 22.
- FLIT_BUFFER_DEPTH=4: five send_in[0] pulses with no credits -> credits_avail[0] steps 4,3,2,1,0. The fifth pulse sets err_overflow[0], and the counter stays at 0.
- Counter at 4, then one credit_out[2] with no send -> err_underflow[2]=1, credits_avail[2] stays 4. The simultaneous case (count 2, send_in and credit_out in the same cycle) -> count stays 2, no error.
- NUM_PIPELINE=0: the forward and reverse paths are combinational, with zero-cycle latency measured over 100 random flits.
- Three-flit packet (tail on the third flit) on link 3 -> in_packet[3] reads 1 after the first two flits and 0 after the tail. With NOC_LINK_PERF_CNT_EN: flit_count[3]=3, pkt_count[3]=1. perf_clear -> both read 0.
- Reset asserted with two flits in flight and credits_avail=2 -> one edge later: send_out=0, credits_avail=4, errors 0. The two in-flight flits never appear.

Source files
------------

// File: rtl/noc_credit_link_pipe_if.sv
// Router-to-router link bundle: per-link flit forward path plus returning credit.
// Master drives the flit fields; slave returns the credit.
interface noc_credit_link_pipe_if #(
  parameter int NUM_LINKS  = 4,
  parameter int FLIT_WIDTH = 128,
  parameter int DEST_WIDTH = 6
);
  logic [NUM_LINKS-1:0][FLIT_WIDTH-1:0] data;
  logic [NUM_LINKS-1:0][DEST_WIDTH-1:0] dest;
  logic [NUM_LINKS-1:0]                 is_tail;
  logic [NUM_LINKS-1:0]                 send;
  logic [NUM_LINKS-1:0]                 credit;

  modport master (output data, dest, is_tail, send, input  credit);
  modport slave  (input  data, dest, is_tail, send, output credit);
endinterface

// File: rtl/noc_credit_link_pipe.sv
// Credit link pipe: NUM_PIPELINE register stages each way (0 = wires), per-link credit monitor.
// No backpressure of its own; credits flow end to end. NOC_LINK_PERF_CNT_EN adds flit/packet counters.
module noc_credit_link_pipe #(
  parameter int NUM_LINKS         = 4,
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 6,
  parameter int NUM_PIPELINE      = 1,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                                clk_noc,
  input  logic                                rst_noc_sync,
  noc_credit_link_pipe_if.slave               up,
  noc_credit_link_pipe_if.master              dn,
  output logic [NUM_LINKS-1:0][CNT_WIDTH-1:0] credits_avail,
  output logic [NUM_LINKS-1:0]                err_overflow,
  output logic [NUM_LINKS-1:0]                err_underflow,
  output logic [NUM_LINKS-1:0]                in_packet,
  input  logic                                perf_clear,
  output logic [NUM_LINKS-1:0][31:0]          flit_count,
  output logic [NUM_LINKS-1:0][31:0]          pkt_count
);

  localparam logic [CNT_WIDTH-1:0] CRED_MAX = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

  logic [NUM_LINKS-1:0] w_credit_up;

  generate
    if (NUM_PIPELINE == 0) begin : g_bypass
      assign dn.data    = up.data;
      assign dn.dest    = up.dest;
      assign dn.is_tail = up.is_tail;
      assign dn.send    = up.send;
      assign up.credit  = dn.credit;
    end else begin : g_pipe
      logic [NUM_LINKS-1:0][FLIT_WIDTH-1:0] r_data   [NUM_PIPELINE];
      logic [NUM_LINKS-1:0][DEST_WIDTH-1:0] r_dest   [NUM_PIPELINE];
      logic [NUM_LINKS-1:0]                 r_tail   [NUM_PIPELINE];
      logic [NUM_LINKS-1:0]                 r_send   [NUM_PIPELINE];
      logic [NUM_LINKS-1:0]                 r_credit [NUM_PIPELINE];

      always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
          for (int s = 0; s < NUM_PIPELINE; s++) begin
            r_data[s]   <= '0;
            r_dest[s]   <= '0;
            r_tail[s]   <= '0;
            r_send[s]   <= '0;
            r_credit[s] <= '0;
          end
        end else begin
          r_send[0]   <= up.send;
          r_credit[0] <= dn.credit;
          // Payload only moves with a valid flit; the valid/credit bits shift every cycle.
          for (int k = 0; k < NUM_LINKS; k++) begin
            if (up.send[k]) begin
              r_data[0][k] <= up.data[k];
              r_dest[0][k] <= up.dest[k];
              r_tail[0][k] <= up.is_tail[k];
            end
          end
          for (int s = 1; s < NUM_PIPELINE; s++) begin
            r_send[s]   <= r_send[s-1];
            r_credit[s] <= r_credit[s-1];
            for (int k = 0; k < NUM_LINKS; k++) begin
              if (r_send[s-1][k]) begin
                r_data[s][k] <= r_data[s-1][k];
                r_dest[s][k] <= r_dest[s-1][k];
                r_tail[s][k] <= r_tail[s-1][k];
              end
            end
          end
        end
      end

      assign dn.data    = r_data[NUM_PIPELINE-1];
      assign dn.dest    = r_dest[NUM_PIPELINE-1];
      assign dn.is_tail = r_tail[NUM_PIPELINE-1];
      assign dn.send    = r_send[NUM_PIPELINE-1];
      assign up.credit  = r_credit[NUM_PIPELINE-1];
    end
  endgenerate

  assign w_credit_up = up.credit;

  logic [NUM_LINKS-1:0][CNT_WIDTH-1:0] r_credits;
  logic [NUM_LINKS-1:0]                r_err_ovf;
  logic [NUM_LINKS-1:0]                r_err_unf;
  logic [NUM_LINKS-1:0]                r_in_pkt;

  // Occupancy as the upstream router sees it: its own sends against credits reaching it.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      for (int k = 0; k < NUM_LINKS; k++) r_credits[k] <= CRED_MAX;
      r_err_ovf <= '0;
      r_err_unf <= '0;
      r_in_pkt  <= '0;
    end else begin
      for (int k = 0; k < NUM_LINKS; k++) begin
        case ({up.send[k], w_credit_up[k]})
          2'b10: begin
            if (r_credits[k] == '0) r_err_ovf[k] <= 1'b1;
            else                    r_credits[k] <= r_credits[k] - CNT_WIDTH'(1);
          end
          2'b01: begin
            if (r_credits[k] == CRED_MAX) r_err_unf[k] <= 1'b1;
            else                          r_credits[k] <= r_credits[k] + CNT_WIDTH'(1);
          end
          default: ;
        endcase
        if (dn.send[k]) r_in_pkt[k] <= ~dn.is_tail[k];
      end
    end
  end

  assign credits_avail = r_credits;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;
  assign in_packet     = r_in_pkt;

`ifdef NOC_LINK_PERF_CNT_EN
  logic [NUM_LINKS-1:0][31:0] r_flit_cnt;
  logic [NUM_LINKS-1:0][31:0] r_pkt_cnt;

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync || perf_clear) begin
      r_flit_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      for (int k = 0; k < NUM_LINKS; k++) begin
        if (dn.send[k] && (r_flit_cnt[k] != 32'hFFFF_FFFF))
          r_flit_cnt[k] <= r_flit_cnt[k] + 32'd1;
        if (dn.send[k] && dn.is_tail[k] && (r_pkt_cnt[k] != 32'hFFFF_FFFF))
          r_pkt_cnt[k] <= r_pkt_cnt[k] + 32'd1;
      end
    end
  end

  assign flit_count = r_flit_cnt;
  assign pkt_count  = r_pkt_cnt;
`else
  logic w_unused_perf_clear;
  assign w_unused_perf_clear = perf_clear;
  assign flit_count = '0;
  assign pkt_count  = '0;
`endif

endmodule

// File: tb/tb_noc_credit_link_pipe.sv
// Bench for noc_credit_link_pipe: a 2-stage instance against a queue/arithmetic reference,
// plus a 0-stage instance checked for zero-latency pass-through.
module tb_noc_credit_link_pipe;
  localparam int NL    = 4;
  localparam int FW    = 128;
  localparam int DW    = 6;
  localparam int NP    = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk_noc      = 1'b0;
  logic rst_noc_sync = 1'b1;
  logic perf_clear   = 1'b0;
  always #5 clk_noc = ~clk_noc;

  noc_credit_link_pipe_if #(.NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW)) up_a ();
  noc_credit_link_pipe_if #(.NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW)) dn_a ();
  noc_credit_link_pipe_if #(.NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW)) up_z ();
  noc_credit_link_pipe_if #(.NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW)) dn_z ();

  logic [NL-1:0][CW-1:0] credits_a, credits_z;
  logic [NL-1:0]         ovf_a, unf_a, pkt_a, ovf_z, unf_z, pkt_z;
  logic [NL-1:0][31:0]   fcnt_a, pcnt_a, fcnt_z, pcnt_z;

  noc_credit_link_pipe #(.NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
                         .NUM_PIPELINE(NP), .FLIT_BUFFER_DEPTH(DEPTH)) dut_a (
    .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync), .up(up_a.slave), .dn(dn_a.master),
    .credits_avail(credits_a), .err_overflow(ovf_a), .err_underflow(unf_a),
    .in_packet(pkt_a), .perf_clear(perf_clear), .flit_count(fcnt_a), .pkt_count(pcnt_a));

  noc_credit_link_pipe #(.NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
                         .NUM_PIPELINE(0), .FLIT_BUFFER_DEPTH(DEPTH)) dut_z (
    .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync), .up(up_z.slave), .dn(dn_z.master),
    .credits_avail(credits_z), .err_overflow(ovf_z), .err_underflow(unf_z),
    .in_packet(pkt_z), .perf_clear(perf_clear), .flit_count(fcnt_z), .pkt_count(pcnt_z));

  typedef struct packed {
    logic [NL-1:0]         send;
    logic [NL-1:0]         tail;
    logic [NL-1:0]         cred;
    logic [NL-1:0][FW-1:0] data;
    logic [NL-1:0][DW-1:0] dest;
  } smp_t;

  smp_t            hist[$];
  smp_t            e;
  int              m_cnt  [NL];
  bit              m_ovf  [NL];
  bit              m_unf  [NL];
  bit              m_pkt  [NL];
  longint unsigned m_fcnt [NL];
  longint unsigned m_pcnt [NL];
  int              n_cmp  = 0;
  int              n_fail = 0;

  task automatic chk(input string tag, input int k, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_fcnt(input int k);
`ifdef NOC_LINK_PERF_CNT_EN
    return 32'(m_fcnt[k]);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_pcnt(input int k);
`ifdef NOC_LINK_PERF_CNT_EN
    return 32'(m_pcnt[k]);
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < NP; i++) hist.push_back('0);
    for (int k = 0; k < NL; k++) begin
      m_cnt[k]  = DEPTH;
      m_ovf[k]  = 1'b0;
      m_unf[k]  = 1'b0;
      m_pkt[k]  = 1'b0;
      m_fcnt[k] = 0;
      m_pcnt[k] = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NL; k++) begin
      chk("send_out",      k, dn_a.send[k],  e.send[k]);
      chk("credit_out",    k, up_a.credit[k], e.cred[k]);
      chk("credits_avail", k, credits_a[k],  128'(m_cnt[k]));
      chk("err_overflow",  k, ovf_a[k],      m_ovf[k]);
      chk("err_underflow", k, unf_a[k],      m_unf[k]);
      chk("in_packet",     k, pkt_a[k],      m_pkt[k]);
      chk("flit_count",    k, fcnt_a[k],     exp_fcnt(k));
      chk("pkt_count",     k, pcnt_a[k],     exp_pcnt(k));
      if (e.send[k]) begin
        chk("data_out",    k, dn_a.data[k],    e.data[k]);
        chk("dest_out",    k, dn_a.dest[k],    e.dest[k]);
        chk("is_tail_out", k, dn_a.is_tail[k], e.tail[k]);
      end
    end
  endtask

  // One clock: sample stimulus, advance the reference at the edge, compare #1 later.
  task automatic cycle();
    smp_t cur;
    cur.send = up_a.send;
    cur.tail = up_a.is_tail;
    cur.cred = dn_a.credit;
    cur.data = up_a.data;
    cur.dest = up_a.dest;
    @(posedge clk_noc);
    if (rst_noc_sync) begin
      model_reset();
    end else begin
      for (int k = 0; k < NL; k++) begin
        if (cur.send[k] && !e.cred[k]) begin
          if (m_cnt[k] == 0) m_ovf[k] = 1'b1;
          else               m_cnt[k] = m_cnt[k] - 1;
        end else if (!cur.send[k] && e.cred[k]) begin
          if (m_cnt[k] == DEPTH) m_unf[k] = 1'b1;
          else                   m_cnt[k] = m_cnt[k] + 1;
        end
        if (e.send[k]) begin
          m_pkt[k] = !e.tail[k];
          if (m_fcnt[k] < 64'hFFFF_FFFF) m_fcnt[k]++;
          if (e.tail[k] && m_pcnt[k] < 64'hFFFF_FFFF) m_pcnt[k]++;
        end
        if (perf_clear) begin
          m_fcnt[k] = 0;
          m_pcnt[k] = 0;
        end
      end
      hist.push_back(cur);
      void'(hist.pop_front());
    end
    e = hist[0];
    #1;
    check_all();
    @(negedge clk_noc);
  endtask

  task automatic drive_idle();
    up_a.send    = '0;
    up_a.is_tail = '0;
    dn_a.credit  = '0;
    perf_clear   = 1'b0;
  endtask

  task automatic send_flit(input int k, input logic tail, input logic [FW-1:0] d, input logic [DW-1:0] ds);
    up_a.send[k]    = 1'b1;
    up_a.is_tail[k] = tail;
    up_a.data[k]    = d;
    up_a.dest[k]    = ds;
  endtask

  initial begin
    logic [NL-1:0]         zs, zt, zc;
    logic [NL-1:0][FW-1:0] zd;
    logic [NL-1:0][DW-1:0] zds;

    drive_idle();
    up_a.data = '0;  up_a.dest = '0;
    up_z.data = '0;  up_z.dest = '0;  up_z.send = '0;  up_z.is_tail = '0;  dn_z.credit = '0;
    e = '0;
    rst_noc_sync = 1'b1;
    cycle();
    cycle();
    rst_noc_sync = 1'b0;

    for (int k = 0; k < NL; k++) begin
      chk("rst_credits",  k, credits_a[k], 128'(DEPTH));
      chk("rst_send_out", k, dn_a.send[k], 1'b0);
      chk("rst_credit_out", k, up_a.credit[k], 1'b0);
      chk("rst_data_out", k, dn_a.data[k], '0);
    end
    repeat (6) cycle();

    // Two-cycle forward latency on link 1, other links quiet.
    send_flit(1, 1'b1, 128'hA5, 6'h15);
    cycle();
    drive_idle();
    chk("fwd_early", 1, dn_a.send[1], 1'b0);
    cycle();
    chk("fwd_send", 1, dn_a.send[1], 1'b1);
    chk("fwd_data", 1, dn_a.data[1], 128'hA5);
    chk("fwd_dest", 1, dn_a.dest[1], 6'h15);
    for (int k = 0; k < NL; k++) if (k != 1) chk("fwd_other", k, dn_a.send[k], 1'b0);
    repeat (6) cycle();
    dn_a.credit[1] = 1'b1;
    cycle();
    drive_idle();
    chk("rev_early", 1, up_a.credit[1], 1'b0);
    cycle();
    chk("rev_credit", 1, up_a.credit[1], 1'b1);
    for (int k = 0; k < NL; k++) if (k != 1) chk("rev_other", k, up_a.credit[k], 1'b0);
    repeat (3) cycle();

    // Overflow on link 0: five sends, no credits back.
    chk("ovf_start", 0, credits_a[0], 128'(DEPTH));
    for (int i = 0; i < 5; i++) begin
      send_flit(0, 1'b1, 128'(i), 6'(i));
      cycle();
      chk("ovf_step", 0, credits_a[0], 128'((i < 4) ? 3 - i : 0));
      chk("ovf_flag", 0, ovf_a[0], 1'(i == 4));
    end
    drive_idle();
    repeat (4) cycle();

    // Link 2: send and credit in the same cycle at count 2, then underflow from a full counter.
    send_flit(2, 1'b1, 128'h22, 6'h2);
    cycle();
    cycle();
    drive_idle();
    chk("sim_cnt_pre", 2, credits_a[2], 128'd2);
    dn_a.credit[2] = 1'b1;
    cycle();
    drive_idle();
    cycle();
    chk("sim_credit_out", 2, up_a.credit[2], 1'b1);
    send_flit(2, 1'b1, 128'h23, 6'h3);
    cycle();
    drive_idle();
    chk("sim_cnt", 2, credits_a[2], 128'd2);
    chk("sim_ovf", 2, ovf_a[2], 1'b0);
    chk("sim_unf", 2, unf_a[2], 1'b0);
    dn_a.credit[2] = 1'b1;
    cycle();
    cycle();
    drive_idle();
    cycle();
    cycle();
    chk("unf_full", 2, credits_a[2], 128'(DEPTH));
    chk("unf_pre", 2, unf_a[2], 1'b0);
    dn_a.credit[2] = 1'b1;
    cycle();
    drive_idle();
    cycle();
    cycle();
    chk("unf_flag", 2, unf_a[2], 1'b1);
    chk("unf_hold", 2, credits_a[2], 128'(DEPTH));

    // Three-flit packet on link 3.
    send_flit(3, 1'b0, 128'h31, 6'h31);
    cycle();
    send_flit(3, 1'b0, 128'h32, 6'h32);
    cycle();
    send_flit(3, 1'b1, 128'h33, 6'h33);
    cycle();
    drive_idle();
    cycle();
    chk("pkt_mid", 3, pkt_a[3], 1'b1);
    cycle();
    chk("pkt_end", 3, pkt_a[3], 1'b0);
`ifdef NOC_LINK_PERF_CNT_EN
    chk("perf_flits", 3, fcnt_a[3], 32'd3);
    chk("perf_pkts",  3, pcnt_a[3], 32'd1);
`else
    chk("perf_flits_off", 3, fcnt_a[3], 32'd0);
    chk("perf_pkts_off",  3, pcnt_a[3], 32'd0);
`endif
    perf_clear = 1'b1;
    cycle();
    perf_clear = 1'b0;
    chk("perf_clr_flits", 3, fcnt_a[3], 32'd0);
    chk("perf_clr_pkts",  3, pcnt_a[3], 32'd0);

    // Reset with two flits in flight on link 1 and two credits held.
    send_flit(1, 1'b1, 128'hAA, 6'h0A);
    cycle();
    drive_idle();
    repeat (3) cycle();
    send_flit(1, 1'b1, 128'hBB, 6'h0B);
    cycle();
    chk("mid_cnt", 1, credits_a[1], 128'd2);
    send_flit(1, 1'b1, 128'hCC, 6'h0C);
    rst_noc_sync = 1'b1;
    cycle();
    rst_noc_sync = 1'b0;
    drive_idle();
    for (int k = 0; k < NL; k++) begin
      chk("mid_send",    k, dn_a.send[k], 1'b0);
      chk("mid_credits", k, credits_a[k], 128'(DEPTH));
      chk("mid_ovf",     k, ovf_a[k], 1'b0);
      chk("mid_unf",     k, unf_a[k], 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mid_gone", 1, dn_a.send[1], 1'b0);
    end

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NL; k++) begin
        up_a.send[k]    = 1'($urandom_range(0, 1));
        up_a.is_tail[k] = ($urandom_range(0, 2) == 0);
        up_a.data[k]    = {$urandom, $urandom, $urandom, $urandom};
        up_a.dest[k]    = DW'($urandom);
        dn_a.credit[k]  = 1'($urandom_range(0, 1));
      end
      perf_clear   = ($urandom_range(0, 49) == 0);
      rst_noc_sync = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst_noc_sync = 1'b0;
    drive_idle();
    cycle();

    // Zero-stage instance: every path is a same-cycle copy.
    for (int i = 0; i < 100; i++) begin
      for (int k = 0; k < NL; k++) begin
        zs[k]  = 1'($urandom_range(0, 1));
        zt[k]  = 1'($urandom_range(0, 1));
        zc[k]  = 1'($urandom_range(0, 1));
        zd[k]  = {$urandom, $urandom, $urandom, $urandom};
        zds[k] = DW'($urandom);
      end
      up_z.send = zs;  up_z.is_tail = zt;  up_z.data = zd;  up_z.dest = zds;  dn_z.credit = zc;
      #1;
      for (int k = 0; k < NL; k++) begin
        chk("z_send",   k, dn_z.send[k],    zs[k]);
        chk("z_tail",   k, dn_z.is_tail[k], zt[k]);
        chk("z_data",   k, dn_z.data[k],    zd[k]);
        chk("z_dest",   k, dn_z.dest[k],    zds[k]);
        chk("z_credit", k, up_z.credit[k],  zc[k]);
      end
      @(negedge clk_noc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
